// File: rtl/hex_display_scan_pkg.sv
// Shared constants for the multiplexed hex display: segment bus width, blank
// pattern and the active-low hex glyph table.
package hex_disp_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low g..a pattern for hex digit n (F listed first).
    localparam logic [15:0][SEG_W-1:0] SEG_ENC = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib);
        return SEG_ENC[nib];
    endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// Value/control inputs and pin-side outputs of the hex display scanner.
interface hex_display_scan_if #(
    parameter int DIGITS = 4
);
    import hex_disp_pkg::*;

    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  lz_en;
    logic [DIGITS-1:0]     blink_mask;
    logic [SEG_W-1:0]      seg;
    logic [DIGITS-1:0]     dig_n;
    logic                  frame_done;

    modport master (
        output load, value, lz_en, blink_mask,
        input  seg, dig_n, frame_done
    );

    modport slave (
        input  load, value, lz_en, blink_mask,
        output seg, dig_n, frame_done
    );

endinterface

// File: rtl/hex_display_scan_seg_enc.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg_enc
    import hex_disp_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = seg_encode(nib);
    end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed common-anode hex display driver with dead cycle per digit,
// leading-zero blanking and per-digit blink.
module hex_display_scan
    import hex_disp_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DWELL        = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input logic              clock,
    input logic              resetn,
    hex_display_scan_if.slave bus
);

    localparam int CNT_W = $clog2(DWELL);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] val_q, val_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRM_W-1:0]    frm_q, frm_d;
    logic                phase_q, phase_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [DIGITS-1:0]   dig_n_q, dig_n_d;
    logic                fd_q, fd_d;

    logic [3:0]          nib;
    logic [SEG_W-1:0]    enc_seg;
    logic                last_cnt, last_dig, lz_blank, blk_blank;

    hex_seg_enc u_enc (
        .nib (nib),
        .seg (enc_seg)
    );

    always_comb begin
        last_cnt  = (cnt_q == CNT_W'(DWELL - 1));
        last_dig  = (idx_q == IDX_W'(DIGITS - 1));
        nib       = val_q[4*idx_q +: 4];
        blk_blank = bus.blink_mask[idx_q] && phase_q;

        // Digit 0 is exempt so an all-zero value still shows a single "0".
        lz_blank = 1'b0;
        if (bus.lz_en && idx_q != '0) begin
            lz_blank = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= int'(idx_q) && val_q[4*i +: 4] != 4'h0) begin
                    lz_blank = 1'b0;
                end
            end
        end

        val_d   = bus.load ? bus.value : val_q;
        cnt_d   = last_cnt ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        if (last_cnt) begin
            idx_d = last_dig ? '0 : idx_q + 1'b1;
        end
        if (last_cnt && last_dig) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end

        // Blinked digits keep their select asserted so brightness stays uniform.
        dig_n_d = (cnt_q == '0) ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d   = (cnt_q == '0 || lz_blank || blk_blank) ? SEG_BLANK : enc_seg;
        fd_d    = last_cnt && last_dig;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            val_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            dig_n_q <= '1;
            fd_q    <= 1'b0;
        end else begin
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dig_n_q <= dig_n_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_done = fd_q;

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
Time-multiplexed driver for DIGITS common-anode seven-segment digits sharing one active-low segment bus. It latches a 4*DIGITS-bit hex value and scans the digits in order. Each digit gets a fixed dwell time, with one dead cycle per digit to prevent ghosting. Optional features are leading-zero blanking and per-digit blinking. Sits between datapath result registers and the board's segment/digit-select pins; successor to the single-digit combinational hex decoder.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
DWELL, 1024, clock cycles per digit slot including the dead cycle (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clock  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
load  in  1  capture value into the display register this cycle
value  in  4*DIGITS  hex digits; nibble i = value[4i+3:4i] shown on digit i
lz_en  in  1  enable leading-zero blanking
blink_mask  in  DIGITS  bit i = 1 makes digit i blink
seg  out  7  active-low segments; bit 0 = a ... bit 6 = g
dig_n  out  DIGITS  active-low one-hot digit select
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (resetn=0, no clock needed): value register 0, cnt 0, idx 0, frame counter 0, blink phase 0, seg=7'h7F, dig_n=all ones, frame_done=0.
- Load: value register <= value on a clock edge with load=1. There is no scan restart; the new value is used from the next cycle.
- cnt counts 0..DWELL-1. When cnt==DWELL-1: cnt<=0 and idx<=idx+1, wrapping DIGITS-1 -> 0.
- Frame end: when cnt==DWELL-1 and idx==DIGITS-1, the frame counter increments. When the frame counter reaches BLINK_FRAMES-1, it resets to 0 and the blink phase toggles.
- All outputs are registered, with one cycle of latency from (cnt, idx):
  - cnt==0 (dead cycle): dig_n=all ones, seg=7'h7F.
  - Otherwise dig_n = ~(1<<idx).
  - seg = 7'h7F if digit idx is blanked, else enc(nibble idx).
- Blanked means either condition holds:
  - (lz_en and idx>0 and nibbles idx..DIGITS-1 are all zero). Digit 0 is never LZ-blanked, so value 0 shows "0".
  - (blink_mask[idx] and blink phase==1). In this case dig_n is still driven, keeping the duty cycle constant.
- frame_done is registered high for exactly one cycle, the cycle after cnt==DWELL-1 and idx==DIGITS-1.
- enc, active-low g..a:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E
- DIGITS=1: idx stays at 0, frame_done pulses every DWELL cycles.
- Simultaneous load and digit advance: the advanced digit displays the newly loaded nibble.
- Reset asserted mid-operation: outputs blank immediately. After release, the scan restarts at digit 0 with cnt 0.

Decomposition:
- Package hex_disp_pkg: SEG_BLANK=7'h7F, segment width constant 7, and the 16-entry encoding constants.
- One sub-module hex_seg_enc: combinational nibble -> active-low segments per the table above. It is instantiated once on the selected nibble.

Test Plan (DIGITS=4, DWELL=4, BLINK_FRAMES=2):
1. Reset, hold 3 clocks -> seg=7F, dig_n=F, frame_done=0. Assert resetn=0 mid-dwell without a clock edge -> outputs immediately 7F/F.
2. load 16'h12AF, lz_en=0 -> each 4-cycle slot is 1 dead cycle (dig_n=F, seg=7F) plus 3 cycles of:
   - dig_n=E, seg=0E
   - dig_n=D, seg=08
   - dig_n=B, seg=24
   - dig_n=7, seg=79
3. lz_en=1, value 16'h0005 -> digits 3, 2, 1 give seg=7F (dig_n still cycling); digit 0 gives seg=12. Then value 16'h0000 -> digit 0 gives seg=40. Then value 16'h0100 -> digit 1 gives seg=40 and digit 2 gives seg=79.
4. Free run -> frame_done high exactly one cycle every 16 cycles, coincident with the first dead cycle of digit 0.
5. blink_mask=4'b0001, value 16'h0008 -> digit 0 shows seg=00 in frames 0-1, seg=7F in frames 2-3, and seg=00 again in frame 4. dig_n for digit 0 is asserted in every frame.
6. load pulse mid-slot of digit 2 changing only nibble 2 from 3 to 7 -> seg changes from 30 to 78 one cycle after the load edge, with idx/cnt sequence undisturbed.
